ahb_to_apb4_bridge_mslv: RTL
============================

// Module: ahb_to_apb4_bridge_mslv
// PURPOSE
//  AHB-Lite slave to APB4 master bridge serving NUM_SLV APB peripherals, one PSEL each, decoded from HADDR.
//  Adds PSTRB/PPROT generation, a two-cycle AHB ERROR response, unmapped-address rejection and an APB wait-state timeout.
//  Sits behind the AHB-Lite decoder; one outstanding transfer, non-pipelined toward APB.
// PARAMETERS
//  ADDR_WIDTH    32  AHB/APB address width
//  DATA_WIDTH    32  data width (32 only; PSTRB width DATA_WIDTH/8)
//  NUM_SLV       4   APB slaves, >=2; IDX_W = $clog2(NUM_SLV)
//  SLV_ADDR_BITS 12  per-slave window size = 2**SLV_ADDR_BITS bytes
//  TIMEOUT_CYC   255 max ACCESS cycles with PREADY low before forced error; 0 disables
// PORTS
//  i_clk        in   1                 clock, all state on rising edge
//  i_reset      in   1                 asynchronous, active-high reset
//  i_hsel       in   1                 AHB slave select
//  i_haddr      in   ADDR_WIDTH        AHB address
//  i_htrans     in   2                 IDLE/BUSY/NONSEQ/SEQ
//  i_hwrite     in   1                 1 = write
//  i_hsize      in   3                 0 byte, 1 half, 2 word
//  i_hprot      in   4                 AHB protection
//  i_hwdata     in   DATA_WIDTH        write data (data phase)
//  i_hreadyin   in   1                 bus HREADY
//  o_hreadyout  out  1                 slave ready
//  o_hresp      out  1                 0 OKAY, 1 ERROR
//  o_hrdata     out  DATA_WIDTH        read data
//  o_psel       out  NUM_SLV           one-hot select
//  o_penable    out  1                 APB access phase
//  o_pwrite     out  1                 APB direction
//  o_paddr      out  ADDR_WIDTH        APB address
//  o_pwdata     out  DATA_WIDTH        APB write data
//  o_pstrb      out  DATA_WIDTH/8      byte strobes, all 0 on reads
//  o_pprot      out  3                 {~hprot[0], 1'b1, hprot[1]}
//  i_pready     in   NUM_SLV           per-slave PREADY
//  i_pslverr    in   NUM_SLV           per-slave PSLVERR
//  i_prdata     in   NUM_SLV*DATA_WIDTH per-slave PRDATA, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (async, any state): state IDLE, o_hreadyout=1, all other outputs and counters 0.
//  Capture: edge with i_hsel & i_hreadyin & i_htrans[1] & state IDLE; latch addr, write, size, prot.
//    idx = haddr[SLV_ADDR_BITS +: IDX_W]; idx>=NUM_SLV -> unmapped -> ERR1, no APB activity.
//  IDLE/BUSY or hsel=0 in IDLE: zero-wait OKAY (hreadyout=1, hresp=0).
//  FSM (all outputs registered, hreadyout=0 from capture until ERR2/DONE):
//    IDLE  -> WDATA (write) | SETUP (read) | ERR1 (unmapped)
//    WDATA : register i_hwdata into o_pwdata, PSTRB from hsize/haddr[1:0] -> SETUP
//    SETUP : o_psel[idx]=1, o_penable=0 -> ACCESS
//    ACCESS: o_penable=1; i_pready[idx]=1: pslverr -> ERR1 else -> DONE (reads latch i_prdata slice into o_hrdata)
//            timeout reached -> ERR1; psel/penable drop in all exits
//    DONE  : hreadyout=1, hresp=0, one cycle -> IDLE (a new capture in DONE is legal and taken)
//    ERR1  : hresp=1, hreadyout=0 -> ERR2
//    ERR2  : hresp=1, hreadyout=1 -> IDLE; any transfer offered here is ignored (master cancels)
//  Latency: read = 3 cycles from capture edge to hreadyout=1 with zero APB waits; write = 4.
//  Timeout counter $clog2(TIMEOUT_CYC+1) bits, cleared on SETUP, +1 per ACCESS cycle with pready low, saturating.
//  Only i_pready/i_pslverr/i_prdata of the selected slave are observed; others ignored.
//  o_hrdata holds last read data until next read completes; cleared to 0 on error.
//  PSTRB: byte -> 1<<a[1:0]; half -> 3<<{a[1],1'b0}; word -> 4'hF.
// TESTING
//  Read 0x0000_1004 (slave 1), pready=1 -> psel=4'b0010, paddr=0x1004, hrdata=prdata[1], hresp=0, 3 cycles
//  Byte write 0x0000_2003 data 0xAA000000 -> psel=4'b0100, pstrb=4'b1000, pwdata=0xAA000000, pwrite=1
//  Write slave 3, pslverr=1 on ready -> hresp=1 two cycles, hreadyout 0 then 1, back to IDLE
//  NUM_SLV=3, access 0x0000_3000 -> no psel, ERR1/ERR2 response
//  TIMEOUT_CYC=4, pready held 0 -> psel drops after 4 ACCESS cycles, ERROR response; reset mid-ACCESS -> all outputs reset value

Source files
------------

// File: rtl/ahb_to_apb4_bridge_mslv_if.sv
// ahb_to_apb4_bridge_mslv_if: AHB-Lite slave side and APB4 master side signals of the bridge.
interface ahb_to_apb4_bridge_mslv_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4
);
    logic                          i_hsel;
    logic [ADDR_WIDTH-1:0]         i_haddr;
    logic [1:0]                    i_htrans;
    logic                          i_hwrite;
    logic [2:0]                    i_hsize;
    logic [3:0]                    i_hprot;
    logic [DATA_WIDTH-1:0]         i_hwdata;
    logic                          i_hreadyin;
    logic                          o_hreadyout;
    logic                          o_hresp;
    logic [DATA_WIDTH-1:0]         o_hrdata;
    logic [NUM_SLV-1:0]            o_psel;
    logic                          o_penable;
    logic                          o_pwrite;
    logic [ADDR_WIDTH-1:0]         o_paddr;
    logic [DATA_WIDTH-1:0]         o_pwdata;
    logic [DATA_WIDTH/8-1:0]       o_pstrb;
    logic [2:0]                    o_pprot;
    logic [NUM_SLV-1:0]            i_pready;
    logic [NUM_SLV-1:0]            i_pslverr;
    logic [NUM_SLV*DATA_WIDTH-1:0] i_prdata;

    modport slave (
        input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hprot, i_hwdata, i_hreadyin,
        input  i_pready, i_pslverr, i_prdata,
        output o_hreadyout, o_hresp, o_hrdata,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot
    );

    modport master (
        output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hprot, i_hwdata, i_hreadyin,
        output i_pready, i_pslverr, i_prdata,
        input  o_hreadyout, o_hresp, o_hrdata,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_pprot
    );
endinterface

// File: rtl/ahb_to_apb4_bridge_mslv.sv
// ahb_to_apb4_bridge_mslv: AHB-Lite slave to multi-slave APB4 bridge with unmapped-address and wait-state timeout errors.
module ahb_to_apb4_bridge_mslv #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_SLV       = 4,
    parameter int SLV_ADDR_BITS = 12,
    parameter int TIMEOUT_CYC   = 255
) (
    input logic                      i_clk,
    input logic                      i_reset,
    ahb_to_apb4_bridge_mslv_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_SLV);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TO_EN  = TIMEOUT_CYC > 0;
    localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    localparam logic [NUM_SLV-1:0] SEL_ONE = NUM_SLV'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              alo_q, alo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic [NUM_SLV-1:0]      psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [2:0]              pprot_q, pprot_d;

    logic                    capture, mapped, sel_ready, sel_err;
    logic [IDX_W-1:0]        cap_idx;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [STRB_W-1:0]       strb;
    logic                    unused_ok;

    assign unused_ok = ^{bus.i_hprot[3:2], bus.i_htrans[0]};
    // A new transfer is accepted from IDLE and also in the DONE cycle, back-to-back.
    assign capture = bus.i_hsel & bus.i_hreadyin & bus.i_htrans[1] & (state_q == S_IDLE || state_q == S_DONE);
    assign cap_idx = bus.i_haddr[SLV_ADDR_BITS +: IDX_W];
    assign mapped  = {1'b0, cap_idx} < (IDX_W + 1)'(NUM_SLV);
    assign strb    = size_q == 3'd0 ? STRB_W'(1) << alo_q :
                     size_q == 3'd1 ? STRB_W'(3) << {alo_q[1], 1'b0} : {STRB_W{1'b1}};

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_ready = bus.i_pready[k];
                sel_err   = bus.i_pslverr[k];
                sel_rdata = bus.i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        size_d    = size_q;
        alo_d     = alo_q;
        cnt_d     = cnt_q;
        hrdata_d  = hrdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (capture) begin
                    idx_d  = cap_idx;
                    size_d = bus.i_hsize;
                    alo_d  = bus.i_haddr[1:0];
                    if (!mapped) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d  = bus.i_hwrite ? S_WDATA : S_SETUP;
                        psel_d   = bus.i_hwrite ? '0 : SEL_ONE << cap_idx;
                        pwrite_d = bus.i_hwrite;
                        paddr_d  = bus.i_haddr;
                        pstrb_d  = '0;
                        pprot_d  = {~bus.i_hprot[0], 1'b1, bus.i_hprot[1]};
                        cnt_d    = '0;
                    end
                end
            end
            S_WDATA: begin
                state_d  = S_SETUP;
                pwdata_d = bus.i_hwdata;
                pstrb_d  = strb;
                psel_d   = SEL_ONE << idx_q;
                cnt_d    = '0;
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (sel_ready || (TO_EN && cnt_q == TO_LAST)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = sel_ready && !sel_err ? S_DONE : S_ERR1;
                    hrdata_d  = sel_ready && !sel_err && !pwrite_q ? sel_rdata : hrdata_q;
                end else begin
                    cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        // Read data is cleared as the error response begins so stale data never accompanies ERROR.
        hrdata_d    = state_d == S_ERR1 ? '0 : hrdata_d;
        hreadyout_d = state_d inside {S_IDLE, S_DONE, S_ERR2};
        hresp_d     = state_d inside {S_ERR1, S_ERR2};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            size_q      <= '0;
            alo_q       <= '0;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            size_q      <= size_d;
            alo_q       <= alo_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
        end
    end

    assign bus.o_hreadyout = hreadyout_q;
    assign bus.o_hresp     = hresp_q;
    assign bus.o_hrdata    = hrdata_q;
    assign bus.o_psel      = psel_q;
    assign bus.o_penable   = penable_q;
    assign bus.o_pwrite    = pwrite_q;
    assign bus.o_paddr     = paddr_q;
    assign bus.o_pwdata    = pwdata_q;
    assign bus.o_pstrb     = pstrb_q;
    assign bus.o_pprot     = pprot_q;
endmodule
